// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier (producer), the product accumulator
// and the downstream consumer of finished sums.
interface product_accumulator_if #(
   parameter int PROD_W = 7,
   parameter int ACC_W  = 12
);
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic              out_ovf;

   modport master (
      output in_valid, in_prod, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, in_prod, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive multiplier products and presents each sum, with a
// sticky carry-out flag, on a valid/ready output; one bubble per result.
module product_accumulator #(
   parameter int PROD_W = 7,
   parameter int ACC_W  = 12,
   parameter int COUNT  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   product_accumulator_if.slave  bus
);
   localparam int CNT_W = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           state_q;
   logic [ACC_W-1:0] acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [ACC_W-1:0] out_sum_q;
   logic             out_ovf_q;

   // One extra bit on the adder captures the carry out of ACC_W bits.
   logic [ACC_W:0]   sum_d;
   logic             last_d;

   always_comb begin
      sum_d  = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
      last_d = (cnt_q == CNT_W'(COUNT - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else if (clear) begin
         // Abort wins over any transfer this cycle; the last sum stays visible but invalid.
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               in_ready_q <= 1'b1;
               if (bus.in_valid && in_ready_q) begin
                  if (last_d) begin
                     out_sum_q   <= sum_d[ACC_W-1:0];
                     out_ovf_q   <= ovf_q | sum_d[ACC_W];
                     acc_q       <= '0;
                     cnt_q       <= '0;
                     ovf_q       <= 1'b0;
                     state_q     <= HOLD;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     acc_q <= sum_d[ACC_W-1:0];
                     ovf_q <= ovf_q | sum_d[ACC_W];
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_q     <= ACCUM;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= ACCUM;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default config, an 8-bit accumulator
// instance for overflow, and a COUNT=1 instance.
module tb_product_accumulator;
   logic clk;
   logic rst_n;
   logic clear;
   int   checks;
   int   failures;

   product_accumulator_if #(.PROD_W(7), .ACC_W(12)) b0 ();
   product_accumulator_if #(.PROD_W(7), .ACC_W(8))  b8 ();
   product_accumulator_if #(.PROD_W(7), .ACC_W(12)) b1 ();

   product_accumulator #(.PROD_W(7), .ACC_W(12), .COUNT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b0.slave));
   product_accumulator #(.PROD_W(7), .ACC_W(8), .COUNT(4)) u8 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b8.slave));
   product_accumulator #(.PROD_W(7), .ACC_W(12), .COUNT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic rdy_of(input int sel);
      case (sel)
         0:       return b0.in_ready;
         1:       return b8.in_ready;
         default: return b1.in_ready;
      endcase
   endfunction

   task automatic drive(input int sel, input logic vld, input int v);
      case (sel)
         0:       begin b0.in_valid = vld; b0.in_prod = 7'(v); end
         1:       begin b8.in_valid = vld; b8.in_prod = 7'(v); end
         default: begin b1.in_valid = vld; b1.in_prod = 7'(v); end
      endcase
   endtask

   // Offers one product and returns #1 after the edge that accepted it.
   task automatic send(input int sel, input int v);
      int n;
      n = 0;
      drive(sel, 1'b1, v);
      while (!rdy_of(sel) && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!rdy_of(sel)) begin
         failures++;
         $display("FAIL send_timeout sel=%0d value=%0d in_ready=0 required=1", sel, v);
      end else begin
         @(posedge clk); #1;
      end
      drive(sel, 1'b0, 0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks += 4;
      if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", b0.in_ready); end
      if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b0.out_valid); end
      if (b0.out_sum !== 12'd0) begin failures++; $display("FAIL reset_out_sum got=%0d exp=0", b0.out_sum); end
      if (b0.out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got=%b exp=0", b0.out_ovf); end
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
      checks += 2;
      if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", b0.in_ready); end
      if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid got=%b exp=0", b0.out_valid); end
      $display("test_reset done");
   endtask

   task automatic test_basic_sum();
      b0.out_ready = 1'b1;
      send(0, 1); send(0, 8); send(0, 15);
      checks++;
      if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", b0.out_valid); end
      send(0, 14);
      checks += 3;
      if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", b0.out_valid); end
      if (b0.out_sum !== 12'h026) begin failures++; $display("FAIL basic_out_sum got=%0d exp=38", b0.out_sum); end
      if (b0.out_ovf !== 1'b0) begin failures++; $display("FAIL basic_out_ovf got=%b exp=0", b0.out_ovf); end
      tick();
      checks += 2;
      if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL basic_taken_valid got=%b exp=0", b0.out_valid); end
      if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL basic_taken_ready got=%b exp=1", b0.in_ready); end
      $display("test_basic_sum sum=%0d", b0.out_sum);
   endtask

   task automatic test_overflow();
      b8.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 105);
      checks += 3;
      if (b8.out_valid !== 1'b1) begin failures++; $display("FAIL ovf_out_valid got=%b exp=1", b8.out_valid); end
      if (b8.out_sum !== 8'd164) begin failures++; $display("FAIL ovf_out_sum got=%0d exp=164", b8.out_sum); end
      if (b8.out_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", b8.out_ovf); end
      b8.out_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) send(1, 1);
      checks += 2;
      if (b8.out_sum !== 8'd4) begin failures++; $display("FAIL ovf_next_sum got=%0d exp=4", b8.out_sum); end
      if (b8.out_ovf !== 1'b0) begin failures++; $display("FAIL ovf_not_sticky got=%b exp=0", b8.out_ovf); end
      tick();
      $display("test_overflow done");
   endtask

   task automatic test_backpressure();
      b0.out_ready = 1'b0;
      send(0, 1); send(0, 8); send(0, 15); send(0, 14);
      for (int i = 0; i < 5; i++) begin
         checks += 3;
         if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, b0.out_valid); end
         if (b0.out_sum !== 12'd38) begin failures++; $display("FAIL bp_sum cyc=%0d got=%0d exp=38", i, b0.out_sum); end
         if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, b0.in_ready); end
         tick();
      end
      b0.out_ready = 1'b1;
      tick();
      checks += 2;
      if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", b0.out_valid); end
      if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", b0.in_ready); end
      $display("test_backpressure done");
   endtask

   task automatic test_gaps();
      int vals[4] = '{3, 5, 7, 9};
      b0.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(0, vals[i]);
         if (i < 3) begin
            for (int g = 0; g < 2; g++) begin
               checks++;
               if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL gap_valid idx=%0d got=%b exp=0", i, b0.out_valid); end
               tick();
            end
         end
      end
      checks += 2;
      if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL gap_out_valid got=%b exp=1", b0.out_valid); end
      if (b0.out_sum !== 12'd24) begin failures++; $display("FAIL gap_out_sum got=%0d exp=24", b0.out_sum); end
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL gap_extra_result cyc=%0d got=%b exp=0", i, b0.out_valid); end
         tick();
      end
      $display("test_gaps done");
   endtask

   task automatic test_clear();
      b0.out_ready = 1'b1;
      send(0, 10); send(0, 20);
      clear = 1'b1;
      drive(0, 1'b1, 50);
      tick();
      clear = 1'b0;
      drive(0, 1'b0, 0);
      send(0, 1); send(0, 2); send(0, 3); send(0, 4);
      checks += 2;
      if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL clr_valid got=%b exp=1", b0.out_valid); end
      if (b0.out_sum !== 12'd10) begin failures++; $display("FAIL clr_sum got=%0d exp=10", b0.out_sum); end
      b0.out_ready = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks += 3;
      if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL clr_hold_valid got=%b exp=0", b0.out_valid); end
      if (b0.out_sum !== 12'd10) begin failures++; $display("FAIL clr_hold_sum_kept got=%0d exp=10", b0.out_sum); end
      if (b0.in_ready !== 1'b1) begin failures++; $display("FAIL clr_hold_ready got=%b exp=1", b0.in_ready); end
      b0.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(0, 5);
      checks++;
      if (b0.out_sum !== 12'd20) begin failures++; $display("FAIL clr_after_sum got=%0d exp=20", b0.out_sum); end
      tick();
      $display("test_clear done");
   endtask

   task automatic test_count_one();
      b1.out_ready = 1'b0;
      send(2, 100);
      checks += 2;
      if (b1.out_valid !== 1'b1) begin failures++; $display("FAIL c1_valid got=%b exp=1", b1.out_valid); end
      if (b1.out_sum !== 12'd100) begin failures++; $display("FAIL c1_sum got=%0d exp=100", b1.out_sum); end
      b1.out_ready = 1'b1;
      tick();
      send(2, 127);
      checks++;
      if (b1.out_sum !== 12'd127) begin failures++; $display("FAIL c1_second_sum got=%0d exp=127", b1.out_sum); end
      tick();
      $display("test_count_one done");
   endtask

   task automatic test_async_reset();
      b0.out_ready = 1'b1;
      send(0, 1); send(0, 2); send(0, 3);
      #2;
      rst_n = 1'b0;
      #1;
      checks += 4;
      if (b0.in_ready !== 1'b0) begin failures++; $display("FAIL areset_in_ready got=%b exp=0", b0.in_ready); end
      if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", b0.out_valid); end
      if (b0.out_sum !== 12'd0) begin failures++; $display("FAIL areset_sum got=%0d exp=0", b0.out_sum); end
      if (b0.out_ovf !== 1'b0) begin failures++; $display("FAIL areset_ovf got=%b exp=0", b0.out_ovf); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) send(0, 2);
      checks += 2;
      if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL areset_after_valid got=%b exp=1", b0.out_valid); end
      if (b0.out_sum !== 12'd8) begin failures++; $display("FAIL areset_after_sum got=%0d exp=8", b0.out_sum); end
      tick();
      $display("test_async_reset done");
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clear    = 1'b0;
      rst_n    = 1'b0;
      drive(0, 1'b0, 0);
      drive(1, 1'b0, 0);
      drive(2, 1'b0, 0);
      b0.out_ready = 1'b1;
      b8.out_ready = 1'b1;
      b1.out_ready = 1'b1;
      test_reset();
      test_basic_sum();
      test_overflow();
      test_backpressure();
      test_gaps();
      test_clear();
      test_count_one();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
